arith_inverse_solver: RTL and testbench

ARITH_INVERSE_SOLVER -- requirements
Module: arith_inverse_solver

---
 rtl/arith_inverse_solver.sv | 190 +++++++++++++++++++
 tb/tb_arith_inverse_solver.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/arith_inverse_solver.sv
// arith_inverse_solver
//
// Recovers dado01 from the relation dado03 = 3*dado01 - 2*dado02.
// It forms N = dado03 + 2*dado02 (10-bit signed, -384..381), then divides
// |N| by 3 with a 9-step restoring divider, one quotient bit per clock,
// MSB first. The sign of N is reapplied to the quotient and the remainder,
// so the quotient truncates toward zero and the remainder takes the sign of N.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high reset
//   start   in   solve request, sampled only while idle
//   dado03  in   signed 8-bit result operand
//   dado02  in   signed 8-bit known operand
//   dado01  out  signed 8-bit recovered quotient (registered)
//   resto   out  signed 3-bit remainder (registered)
//   exact   out  high when resto == 0 (registered)
//   busy    out  high during the nine iteration cycles (registered)
//   done    out  one-cycle completion pulse (registered)

module arith_inverse_solver (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic signed [7:0] dado03,
    input  logic signed [7:0] dado02,
    output logic signed [7:0] dado01,
    output logic signed [2:0] resto,
    output logic              exact,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;

    logic [3:0] cnt_r;      // iterations left after the current one
    logic [8:0] mag_r;      // |N|, shifted left one bit per iteration
    logic [7:0] quo_r;      // quotient bits collected so far
    logic [1:0] rem_r;      // partial remainder, always below 3
    logic       neg_r;      // N was negative

    logic [9:0] n_s;
    logic [9:0] n_abs_s;
    logic [2:0] trial_s;
    logic       q_bit_s;
    logic [1:0] rem_next_s;
    logic [7:0] quo_full_s;

    // Two's-complement negate when sel is set. Used to reapply the sign of N.
    function automatic logic [7:0] cond_neg8(input logic sel, input logic [7:0] v);
        logic [7:0] r;
        if (sel) begin
            r = 8'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [2:0] cond_neg3(input logic sel, input logic [2:0] v);
        logic [2:0] r;
        if (sel) begin
            r = 3'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Operand combination: N = dado03 + 2*dado02 at full 10-bit width, and |N|.
    always_comb begin
        n_s = {{2{dado03[7]}}, dado03} + {dado02[7], dado02, 1'b0};
        if (n_s[9]) begin
            n_abs_s = 10'd0 - n_s;   // -384 maps to 384, which still fits 9 bits
        end else begin
            n_abs_s = n_s;
        end
    end

    // One restoring step: bring down the next dividend bit and try to subtract 3.
    always_comb begin
        trial_s = {rem_r, mag_r[8]};
        if (trial_s >= 3'd3) begin
            q_bit_s    = 1'b1;
            rem_next_s = 2'(trial_s - 3'd3);
        end else begin
            q_bit_s    = 1'b0;
            rem_next_s = trial_s[1:0];
        end
        // The first quotient bit out is always 0 (|N|/3 <= 128), so eight
        // bits hold the whole quotient once the ninth bit is appended.
        quo_full_s = {quo_r[6:0], q_bit_s};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = CALC;
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == 4'd0) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, result and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r  <= 4'd0;
            mag_r  <= 9'd0;
            quo_r  <= 8'd0;
            rem_r  <= 2'd0;
            neg_r  <= 1'b0;
            dado01 <= 8'sd0;
            resto  <= 3'sd0;
            exact  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            // Status flags follow the state being entered, so they line up with it.
            busy <= (state_s == CALC);
            done <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    if (start) begin
                        mag_r <= n_abs_s[8:0];
                        neg_r <= n_s[9];
                        cnt_r <= 4'd8;
                        quo_r <= 8'd0;
                        rem_r <= 2'd0;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                CALC: begin
                    mag_r <= {mag_r[7:0], 1'b0};
                    quo_r <= quo_full_s;
                    rem_r <= rem_next_s;
                    if (cnt_r == 4'd0) begin
                        // Last step: publish results. They then hold until the next solve ends.
                        dado01 <= cond_neg8(neg_r, quo_full_s);
                        resto  <= cond_neg3(neg_r, {1'b0, rem_next_s});
                        exact  <= (rem_next_s == 2'd0);
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                DONE: begin
                    cnt_r <= 4'd0;
                end
                default: begin
                    cnt_r <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arith_inverse_solver.sv
// Directed bench for arith_inverse_solver: a vector table of operands with
// hand-computed quotient/remainder, plus sequences for mid-solve input
// changes, reset during a solve, and back-to-back solves with start held.

module tb_arith_inverse_solver;

    logic              clk;
    logic              reset;
    logic              start;
    logic signed [7:0] dado03;
    logic signed [7:0] dado02;
    logic signed [7:0] dado01;
    logic signed [2:0] resto;
    logic              exact;
    logic              busy;
    logic              done;

    int n_cmp;
    int n_bad;

    arith_inverse_solver dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .dado03 (dado03),
        .dado02 (dado02),
        .dado01 (dado01),
        .resto  (resto),
        .exact  (exact),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;      // dado03
        int b;      // dado02
        int q;      // expected dado01
        int r;      // expected resto
        int ex;     // expected exact
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One solve: start pulse, then wait (bounded) for done.
    // lat counts edges from the start edge to done; bcnt counts busy cycles;
    // unstable counts cycles before done where dado01 moved.
    // If glitch > 0 the operands change and start pulses again at that point.
    task automatic run(input int a, input int b, input int glitch,
                       output int lat, output int bcnt, output int unstable);
        int prev;
        @(negedge clk);
        prev   = int'(dado01);
        dado03 = 8'(a);
        dado02 = 8'(b);
        start  = 1'b1;
        @(posedge clk);
        lat = 1;
        bcnt = 0;
        unstable = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 20) begin
            if (busy) bcnt++;
            if (int'(dado01) != prev) unstable++;
            if (lat == glitch) begin
                dado03 = -8'sd100;
                dado02 = 8'sd50;
                start  = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_solve(input string tag, input int a, input int b, input int glitch,
                               input int q, input int r, input int ex);
        int lat, bcnt, uns;
        run(a, b, glitch, lat, bcnt, uns);
        chk({tag, "_q"}, int'(dado01), q);
        chk({tag, "_r"}, int'(resto), r);
        chk({tag, "_exact"}, int'(exact), ex);
        chk({tag, "_latency"}, lat, 10);
        chk({tag, "_busy_cycles"}, bcnt, 9);
        chk({tag, "_hold"}, uns, 0);
        @(negedge clk);
        chk({tag, "_done_1cyc"}, int'(done), 0);
        chk({tag, "_q_held"}, int'(dado01), q);
    endtask

    initial begin
        int pulses, t, last, guard;
        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{9, 3, 5, 0, 1};          // N = 15
        vecs[1] = '{-14, 2, -3, -1, 0};      // N = -10
        vecs[2] = '{-128, -128, -128, 0, 1}; // N = -384
        vecs[3] = '{127, 127, 127, 0, 1};    // N = 381
        vecs[4] = '{10, 0, 3, 1, 0};         // N = 10
        vecs[5] = '{-1, 0, 0, -1, 0};        // N = -1
        vecs[6] = '{0, -1, 0, -2, 0};        // N = -2
        vecs[7] = '{-7, 1, -1, -2, 0};       // N = -5
        vecs[8] = '{100, -50, 0, 0, 1};      // N = 0
        vecs[9] = '{127, 0, 42, 1, 0};       // N = 127

        // Reset with start high: reset must win.
        reset  = 1'b1;
        start  = 1'b1;
        dado03 = 8'sd9;
        dado02 = 8'sd3;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        chk("rst_q", int'(dado01), 0);
        chk("rst_r", int'(resto), 0);
        chk("rst_exact", int'(exact), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        @(negedge clk);
        chk("rst_wins_busy", int'(busy), 0);

        for (int i = 0; i < 10; i++) begin
            check_solve($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, 0,
                        vecs[i].q, vecs[i].r, vecs[i].ex);
        end

        // Inputs change and start pulses mid-solve: operands 20,5 -> N=30 -> 10.
        check_solve("glitch", 20, 5, 3, 10, 0, 1);
        // Next solve: dado01 must keep 10 throughout CALC, then become 1.
        check_solve("after_glitch", 1, 1, 0, 1, 0, 1);

        // Reset in the 5th CALC cycle.
        @(negedge clk);
        dado03 = 8'sd50;
        dado02 = 8'sd10;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_q", int'(dado01), 0);
        chk("abort_r", int'(resto), 0);
        chk("abort_exact", int'(exact), 1);
        pulses = 0;
        repeat (12) begin
            if (done) pulses++;
            @(negedge clk);
        end
        chk("abort_no_done", pulses, 0);
        check_solve("post_abort", 19, 1, 0, 7, 0, 1);

        // Back-to-back with start held for 25 cycles.
        @(negedge clk);
        dado03 = 8'sd0;
        dado02 = 8'sd0;
        start  = 1'b1;
        t = 0;
        last = -1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            @(negedge clk);
            t++;
            if (done) begin
                if (last >= 0) chk("b2b_spacing", t - last, 11);
                chk("b2b_q", int'(dado01), 0);
                chk("b2b_exact", int'(exact), 1);
                last = t;
                pulses++;
            end
        end
        start = 1'b0;
        chk("b2b_pulses", pulses, 2);
        chk("b2b_first_done", last - 11, 10);
        guard = 0;
        while ((busy || done) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("b2b_drain_timeout", int'(guard < 20), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
